// File: rtl/madd_et_checker.sv
// madd_et_checker: sweeps all 64 input vectors of an approximate 6-in/4-out
// multiply-add netlist, computes the exact reference a*b+c internally, and
// accumulates error statistics against the threshold ET.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           one-cycle pulse, starts a sweep from IDLE or DONE
//   o_stim/o_stim_vld vector driven to the netlist and its valid flag
//   i_approx          netlist result, sampled DUT_LAT cycles after o_stim
//   o_busy/o_done     sweep/drain in progress; sweep complete (sticky)
//   o_max_err, o_err_cnt, o_viol_cnt, o_sum_err, o_pass   statistics
//   o_first_fail, o_first_fail_vld  index of first vector with err > ET
//
// Optional feature macro: MADD_CHK_FIRSTFAIL_EN adds the first-fail capture.
// DUT_LAT must be in 0..7.
module madd_et_checker #(
    parameter int unsigned ET      = 8,
    parameter int unsigned DUT_LAT = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic [5:0] o_stim,
    output logic       o_stim_vld,
    input  logic [3:0] i_approx,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_max_err,
    output logic [6:0] o_err_cnt,
    output logic [6:0] o_viol_cnt,
    output logic [9:0] o_sum_err,
`ifdef MADD_CHK_FIRSTFAIL_EN
    output logic [5:0] o_first_fail,
    output logic       o_first_fail_vld,
`endif
    output logic       o_pass
);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e     r_state, w_state_next;
    logic [5:0] r_cnt;
    logic [3:0] r_drain;
    logic       w_start_acc;

    logic       w_al_vld;
    logic [5:0] w_al_stim;
    logic [3:0] w_exact;
    logic [3:0] w_err;
    logic       w_viol;

    logic [3:0] r_max_err;
    logic [6:0] r_err_cnt;
    logic [6:0] r_viol_cnt;
    logic [9:0] r_sum_err;

    assign w_start_acc = i_start && ((r_state == StIdle) || (r_state == StDone));

    // Next-state logic. DRAIN lasts DUT_LAT+2 cycles so that done rises
    // 64 + DUT_LAT + 2 cycles after the start pulse, after the final update.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StSweep;
            StSweep: if (r_cnt == 6'd63) w_state_next = StDrain;
            StDrain: if (r_drain == 4'(DUT_LAT + 1)) w_state_next = StDone;
            StDone:  if (i_start) w_state_next = StSweep;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_acc) begin
                r_cnt <= '0;
            end else if ((r_state == StSweep) && (r_cnt != 6'd63)) begin
                r_cnt <= r_cnt + 6'd1;
            end
            r_drain <= (r_state == StDrain) ? r_drain + 4'd1 : 4'd0;
        end
    end

    assign o_stim     = r_cnt;
    assign o_stim_vld = (r_state == StSweep);
    assign o_busy     = (r_state == StSweep) || (r_state == StDrain);
    assign o_done     = (r_state == StDone);
    assign o_pass     = o_done && (r_viol_cnt == 7'd0);

    // Delay the vector and its valid flag to line up with the netlist result;
    // the exact value is recomputed from the delayed vector.
    if (DUT_LAT == 0) begin : g_nolat
        assign w_al_vld  = o_stim_vld;
        assign w_al_stim = r_cnt;
    end else begin : g_lat
        logic [DUT_LAT-1:0] r_vld_pipe;
        logic [5:0]         r_stim_pipe [DUT_LAT];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= o_stim_vld;
                for (int i = 1; i < DUT_LAT; i++) begin
                    r_vld_pipe[i] <= r_vld_pipe[i-1];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            r_stim_pipe[0] <= r_cnt;
            for (int i = 1; i < DUT_LAT; i++) begin
                r_stim_pipe[i] <= r_stim_pipe[i-1];
            end
        end

        assign w_al_vld  = r_vld_pipe[DUT_LAT-1];
        assign w_al_stim = r_stim_pipe[DUT_LAT-1];
    end

    assign w_exact = {2'b00, w_al_stim[1:0]} * {2'b00, w_al_stim[3:2]}
                   + {2'b00, w_al_stim[5:4]};
    assign w_err   = (w_exact >= i_approx) ? (w_exact - i_approx) : (i_approx - w_exact);
    assign w_viol  = 32'(w_err) > ET;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_acc) begin
            r_max_err  <= '0;
            r_err_cnt  <= '0;
            r_viol_cnt <= '0;
            r_sum_err  <= '0;
        end else if (w_al_vld) begin
            if (w_err > r_max_err) r_max_err <= w_err;
            r_err_cnt  <= r_err_cnt + 7'(w_err != 4'd0);
            r_viol_cnt <= r_viol_cnt + 7'(w_viol);
            r_sum_err  <= r_sum_err + 10'(w_err);
        end
    end

    assign o_max_err  = r_max_err;
    assign o_err_cnt  = r_err_cnt;
    assign o_viol_cnt = r_viol_cnt;
    assign o_sum_err  = r_sum_err;

`ifdef MADD_CHK_FIRSTFAIL_EN
    logic [5:0] r_first_fail;
    logic       r_first_fail_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_acc) begin
            r_first_fail     <= '0;
            r_first_fail_vld <= 1'b0;
        end else if (w_al_vld && w_viol && !r_first_fail_vld) begin
            r_first_fail     <= w_al_stim;
            r_first_fail_vld <= 1'b1;
        end
    end

    assign o_first_fail     = r_first_fail;
    assign o_first_fail_vld = r_first_fail_vld;
`endif

endmodule

// File: tb/tb_madd_et_checker.sv
// Directed bench for madd_et_checker: one instance with DUT_LAT=0 and one
// with DUT_LAT=3, each fed by a behavioural netlist whose fault pattern is
// chosen by 'mode'. Expected statistics are hand-computed constants.
module tb_madd_et_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start0 = 1'b0, start3 = 1'b0;
    logic [5:0] stim0, stim3;
    logic       vld0, vld3;
    logic [3:0] approx0, approx3;
    logic       busy0, busy3, done0, done3, pass0, pass3;
    logic [3:0] max0, max3;
    logic [6:0] errc0, errc3, violc0, violc3;
    logic [9:0] sum0, sum3;
`ifdef MADD_CHK_FIRSTFAIL_EN
    logic [5:0] ff0, ff3;
    logic       ffv0, ffv3;
`endif

    // 0: exact, 1: tied to zero, 2: exact except 0x3F -> 0, 3: exact + 1
    int mode = 0;
    int checks = 0;
    int failures = 0;

    function automatic logic [3:0] netlist(input int m, input logic [5:0] s);
        logic [3:0] ex;
        ex = {2'b00, s[1:0]} * {2'b00, s[3:2]} + {2'b00, s[5:4]};
        case (m)
            1:       return 4'd0;
            2:       return (s == 6'd63) ? 4'd0 : ex;
            3:       return ex + 4'd1;
            default: return ex;
        endcase
    endfunction

    always_comb approx0 = netlist(mode, stim0);

    logic [5:0] pipe3 [3] = '{default: 6'd0};
    always @(posedge clk) begin
        pipe3[0] <= stim3;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    always_comb approx3 = netlist(mode, pipe3[2]);

    madd_et_checker #(.ET(8), .DUT_LAT(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0),
        .o_stim(stim0), .o_stim_vld(vld0), .i_approx(approx0),
        .o_busy(busy0), .o_done(done0), .o_max_err(max0), .o_err_cnt(errc0),
        .o_viol_cnt(violc0), .o_sum_err(sum0),
`ifdef MADD_CHK_FIRSTFAIL_EN
        .o_first_fail(ff0), .o_first_fail_vld(ffv0),
`endif
        .o_pass(pass0)
    );

    madd_et_checker #(.ET(8), .DUT_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start3),
        .o_stim(stim3), .o_stim_vld(vld3), .i_approx(approx3),
        .o_busy(busy3), .o_done(done3), .o_max_err(max3), .o_err_cnt(errc3),
        .o_viol_cnt(violc3), .o_sum_err(sum3),
`ifdef MADD_CHK_FIRSTFAIL_EN
        .o_first_fail(ff3), .o_first_fail_vld(ffv3),
`endif
        .o_pass(pass3)
    );

    // Pulse start on the LAT=0 instance and count cycles until done (bounded).
    task automatic sweep0(output int cyc);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic sweep3(output int cyc);
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (stim0 !== 6'd0) begin failures++; $display("FAIL reset_stim got %0d expected 0", stim0); end
        checks++; if (vld0 !== 1'b0) begin failures++; $display("FAIL reset_vld got %0d expected 0", vld0); end
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("FAIL reset_busy_done got %0d/%0d expected 0/0", busy0, done0); end
        checks++; if (max0 !== 4'd0 || errc0 !== 7'd0 || violc0 !== 7'd0 || sum0 !== 10'd0) begin failures++; $display("FAIL reset_stats got %0d/%0d/%0d/%0d expected 0/0/0/0", max0, errc0, violc0, sum0); end
        checks++; if (pass0 !== 1'b0 || pass3 !== 1'b0) begin failures++; $display("FAIL reset_pass got %0d/%0d expected 0/0", pass0, pass3); end
`ifdef MADD_CHK_FIRSTFAIL_EN
        checks++; if (ffv0 !== 1'b0 || ff0 !== 6'd0) begin failures++; $display("FAIL reset_first_fail got %0d/%0d expected 0/0", ffv0, ff0); end
`endif
    endtask

    task automatic test_loopback;
        int cyc;
        mode = 0;
        sweep0(cyc);
        checks++; if (cyc !== 66) begin failures++; $display("FAIL loop_cycles got %0d expected 66", cyc); end
        checks++; if (max0 !== 4'd0 || errc0 !== 7'd0 || violc0 !== 7'd0 || sum0 !== 10'd0) begin failures++; $display("FAIL loop_stats got %0d/%0d/%0d/%0d expected 0/0/0/0", max0, errc0, violc0, sum0); end
        checks++; if (pass0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL loop_pass_busy got %0d/%0d expected 1/0", pass0, busy0); end
        checks++; if (stim0 !== 6'd63 || vld0 !== 1'b0) begin failures++; $display("FAIL loop_stim_hold got %0d/%0d expected 63/0", stim0, vld0); end
    endtask

    // Zero output: 7 vectors have exact 0, 6 exceed 8, sum 240. The first
    // violation in sweep order is index 0x0F (a=3, b=3, c=0, exact 9).
    task automatic test_zero;
        int cyc;
        mode = 1;
        sweep0(cyc);
        checks++; if (cyc !== 66) begin failures++; $display("FAIL zero_cycles got %0d expected 66", cyc); end
        checks++; if (max0 !== 4'd12) begin failures++; $display("FAIL zero_max got %0d expected 12", max0); end
        checks++; if (errc0 !== 7'd57) begin failures++; $display("FAIL zero_err_cnt got %0d expected 57", errc0); end
        checks++; if (violc0 !== 7'd6) begin failures++; $display("FAIL zero_viol_cnt got %0d expected 6", violc0); end
        checks++; if (sum0 !== 10'd240) begin failures++; $display("FAIL zero_sum got %0d expected 240", sum0); end
        checks++; if (pass0 !== 1'b0) begin failures++; $display("FAIL zero_pass got %0d expected 0", pass0); end
`ifdef MADD_CHK_FIRSTFAIL_EN
        checks++; if (ffv0 !== 1'b1 || ff0 !== 6'h0F) begin failures++; $display("FAIL zero_first_fail got %0d/%0d expected 1/15", ffv0, ff0); end
`endif
    endtask

    task automatic test_lat3;
        int cyc;
        mode = 2;
        sweep3(cyc);
        checks++; if (cyc !== 69) begin failures++; $display("FAIL lat3_cycles got %0d expected 69", cyc); end
        checks++; if (max3 !== 4'd12 || errc3 !== 7'd1 || violc3 !== 7'd1 || sum3 !== 10'd12) begin failures++; $display("FAIL lat3_stats got %0d/%0d/%0d/%0d expected 12/1/1/12", max3, errc3, violc3, sum3); end
        checks++; if (pass3 !== 1'b0) begin failures++; $display("FAIL lat3_pass got %0d expected 0", pass3); end
`ifdef MADD_CHK_FIRSTFAIL_EN
        checks++; if (ffv3 !== 1'b1 || ff3 !== 6'd63) begin failures++; $display("FAIL lat3_first_fail got %0d/%0d expected 1/63", ffv3, ff3); end
`endif
    endtask

    task automatic test_plus_one;
        int cyc;
        mode = 3;
        sweep0(cyc);
        checks++; if (cyc !== 66) begin failures++; $display("FAIL plus1_cycles got %0d expected 66", cyc); end
        checks++; if (max0 !== 4'd1 || errc0 !== 7'd64 || violc0 !== 7'd0 || sum0 !== 10'd64) begin failures++; $display("FAIL plus1_stats got %0d/%0d/%0d/%0d expected 1/64/0/64", max0, errc0, violc0, sum0); end
        checks++; if (pass0 !== 1'b1) begin failures++; $display("FAIL plus1_pass got %0d expected 1", pass0); end
`ifdef MADD_CHK_FIRSTFAIL_EN
        checks++; if (ffv0 !== 1'b0) begin failures++; $display("FAIL plus1_first_fail_vld got %0d expected 0", ffv0); end
`endif
    endtask

    task automatic test_start_ignored;
        int cyc;
        mode = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start0 = (cyc == 10 || cyc == 65);
        end
        start0 = 1'b0;
        checks++; if (cyc !== 66) begin failures++; $display("FAIL ignore_cycles got %0d expected 66", cyc); end
        checks++; if (pass0 !== 1'b1 || sum0 !== 10'd0) begin failures++; $display("FAIL ignore_result got %0d/%0d expected 1/0", pass0, sum0); end
    endtask

    task automatic test_rerun;
        int cyc;
        mode = 1;
        sweep0(cyc);
        checks++; if (errc0 !== 7'd57 || sum0 !== 10'd240) begin failures++; $display("FAIL rerun_first got %0d/%0d expected 57/240", errc0, sum0); end
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        checks++; if (errc0 !== 7'd0 || sum0 !== 10'd0 || done0 !== 1'b0 || busy0 !== 1'b1) begin failures++; $display("FAIL rerun_clear got %0d/%0d/%0d/%0d expected 0/0/0/1", errc0, sum0, done0, busy0); end
        cyc = 0;
        while (!done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 66) begin failures++; $display("FAIL rerun_cycles got %0d expected 66", cyc); end
        checks++; if (max0 !== 4'd12 || errc0 !== 7'd57 || violc0 !== 7'd6 || sum0 !== 10'd240 || pass0 !== 1'b0) begin failures++; $display("FAIL rerun_stats got %0d/%0d/%0d/%0d/%0d expected 12/57/6/240/0", max0, errc0, violc0, sum0, pass0); end
    endtask

    // Vectors 0..29 are accumulated when stim shows 30; 7 of them are exact 0.
    task automatic test_abort;
        int n;
        mode = 1;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        n = 0;
        while (stim0 != 6'd30 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (stim0 !== 6'd30 || errc0 !== 7'd23) begin failures++; $display("FAIL abort_pre got %0d/%0d expected 30/23", stim0, errc0); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (stim0 !== 6'd0 || vld0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("FAIL abort_ctrl got %0d/%0d/%0d/%0d expected 0/0/0/0", stim0, vld0, busy0, done0); end
        checks++; if (max0 !== 4'd0 || errc0 !== 7'd0 || violc0 !== 7'd0 || sum0 !== 10'd0 || pass0 !== 1'b0) begin failures++; $display("FAIL abort_stats got %0d/%0d/%0d/%0d/%0d expected 0/0/0/0/0", max0, errc0, violc0, sum0, pass0); end
`ifdef MADD_CHK_FIRSTFAIL_EN
        checks++; if (ffv0 !== 1'b0 || ff0 !== 6'd0) begin failures++; $display("FAIL abort_first_fail got %0d/%0d expected 0/0", ffv0, ff0); end
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || stim0 !== 6'd0) begin failures++; $display("FAIL abort_idle got %0d/%0d/%0d expected 0/0/0", busy0, done0, stim0); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_zero();
        test_lat3();
        test_plus_one();
        test_start_ignored();
        test_rerun();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
